// File: rtl/otp_pingpong_xor.sv
// otp_pingpong_xor: two-bank ping-pong keystream buffer; raw words are XORed with stored key words.
// Optional macro OTP_ZEROIZE_EN: each consumed key location is overwritten with zero as it is read.
module otp_pingpong_xor #(
    parameter int DATA_W     = 4,
    parameter int DEPTH      = 1024,
    parameter int RAM_BLOCKS = 8
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              ikey_valid,
    input  logic [DATA_W-1:0] ikey_data,
    output logic              okey_ready,
    input  logic              iraw_valid,
    input  logic [DATA_W-1:0] iraw_data,
    output logic              oraw_ready,
    input  logic              idiscard,
    output logic              ores_valid,
    output logic [DATA_W-1:0] ores_data,
    output logic [1:0]        ofull_banks,
    output logic              oerr
);
    localparam int BANK_WORDS = DEPTH * RAM_BLOCKS;
    localparam int AW = $clog2(BANK_WORDS);
    localparam logic [AW-1:0] LAST = AW'(BANK_WORDS - 1);

    logic [DATA_W-1:0] mem0 [BANK_WORDS];
    logic [DATA_W-1:0] mem1 [BANK_WORDS];
    logic [1:0]        full, full_n;
    logic              fb, db;
    logic [AW-1:0]     wp, rp;
    logic              key_acc, raw_acc, drop, fill_done, drain_done;
    logic [DATA_W-1:0] key_rd;
    logic              we0, we1;
    logic [AW-1:0]     wa0, wa1;
    logic [DATA_W-1:0] wd0, wd1;

    assign okey_ready = ~full[fb];
    assign oraw_ready = full[db];

    // Handshakes, bank completion events and next FULL state of both banks
    always_comb begin
        key_acc    = ikey_valid & ~full[fb];
        raw_acc    = iraw_valid & full[db] & ~idiscard;
        drop       = idiscard & full[db];
        fill_done  = key_acc & (wp == LAST);
        drain_done = (raw_acc & (rp == LAST)) | drop;
        full_n     = full;
        if (fill_done) full_n[fb] = 1'b1;
        if (drain_done) full_n[db] = 1'b0;
        key_rd     = db ? mem1[rp] : mem0[rp];
    end

`ifdef OTP_ZEROIZE_EN
    // Per-bank write port: fill has the port when filling that bank, otherwise a drain zeroizes
    always_comb begin
        we0 = ~irst & ((key_acc & ~fb) | (raw_acc & ~db));
        wa0 = (key_acc & ~fb) ? wp : rp;
        wd0 = (key_acc & ~fb) ? ikey_data : '0;
        we1 = ~irst & ((key_acc & fb) | (raw_acc & db));
        wa1 = (key_acc & fb) ? wp : rp;
        wd1 = (key_acc & fb) ? ikey_data : '0;
    end
`else
    // Per-bank write port driven only by the fill side
    always_comb begin
        we0 = ~irst & key_acc & ~fb;
        wa0 = wp;
        wd0 = ikey_data;
        we1 = ~irst & key_acc & fb;
        wa1 = wp;
        wd1 = ikey_data;
    end
`endif

    // Bank 0 storage, contents deliberately not reset
    always_ff @(posedge iclk) begin
        if (we0) mem0[wa0] <= wd0;
    end

    // Bank 1 storage, contents deliberately not reset
    always_ff @(posedge iclk) begin
        if (we1) mem1[wa1] <= wd1;
    end

    // Bank state, pointers, result register and sticky error
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            full        <= '0;
            fb          <= 1'b0;
            db          <= 1'b0;
            wp          <= '0;
            rp          <= '0;
            ores_valid  <= 1'b0;
            ores_data   <= '0;
            ofull_banks <= '0;
            oerr        <= 1'b0;
        end else begin
            full        <= full_n;
            ofull_banks <= {1'b0, full_n[0]} + {1'b0, full_n[1]};
            if (key_acc) wp <= fill_done ? '0 : wp + AW'(1);
            fb          <= fb ^ fill_done;
            if (raw_acc) rp <= (rp == LAST) ? '0 : rp + AW'(1);
            else if (drop) rp <= '0;
            db          <= db ^ drain_done;
            ores_valid  <= raw_acc;
            if (raw_acc) ores_data <= iraw_data ^ key_rd;
            oerr        <= oerr | (iraw_valid & ~full[db] & ~idiscard);
        end
    end
endmodule
